// File: rtl/link_anim_ctrl.sv
// Player sprite animation sequencer: tracks facing, walk cycle and attack pose per frame tick
// and drives the registered sprite/palette select used by the color mapper.
module link_anim_ctrl #(
    parameter int WALK_PERIOD   = 8,
    parameter int ATTACK_FRAMES = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [1:0] dir_in,
    input  logic       moving,
    input  logic       attack_req,
    output logic [3:0] sprite_sel,
    output logic       attack_busy
);

    // state  | meaning
    // IDLE   | standing, pose 00
    // WALK_A | walking, first pose 00
    // WALK_B | walking, second pose 01
    // ATTACK | attack pose 10 held for ATTACK_FRAMES frames, dir frozen
    typedef enum logic [1:0] {IDLE, WALK_A, WALK_B, ATTACK} state_t;

    localparam logic [7:0] WALK_LAST = 8'(WALK_PERIOD - 1);
    localparam logic [7:0] ATK_LAST  = 8'(ATTACK_FRAMES - 1);

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [1:0] dir_reg, dir_nx;
    logic       frame_q;
    logic       atk_pend, atk_pend_nx;
    logic       tick;
    logic       atk_any;
    logic [1:0] pose_nx;

    assign tick    = frame_clk & ~frame_q;
    assign atk_any = atk_pend | attack_req;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (atk_any)     state_nx = ATTACK;
                    else if (moving) state_nx = WALK_A;
                end
                WALK_A, WALK_B: begin
                    if (atk_any)               state_nx = ATTACK;
                    else if (!moving)          state_nx = IDLE;
                    else if (cnt == WALK_LAST) state_nx = (state == WALK_A) ? WALK_B : WALK_A;
                    else                       cnt_nx = cnt + 8'd1;
                end
                ATTACK: begin
                    if (cnt == ATK_LAST) state_nx = IDLE;
                    else                 cnt_nx = cnt + 8'd1;
                end
                default: state_nx = IDLE;
            endcase
        end
        if (state_nx != state) cnt_nx = 8'd0;

        dir_nx = (tick && state_nx != ATTACK) ? dir_in : dir_reg;

        // Entering ATTACK consumes the request, even one arriving in that same cycle
        if (state_nx == ATTACK && state != ATTACK) atk_pend_nx = 1'b0;
        else if (attack_req && state != ATTACK)    atk_pend_nx = 1'b1;
        else                                       atk_pend_nx = atk_pend;

        case (state_nx)
            WALK_B:  pose_nx = 2'b01;
            ATTACK:  pose_nx = 2'b10;
            default: pose_nx = 2'b00;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            dir_reg     <= 2'd0;
            frame_q     <= 1'b0;
            atk_pend    <= 1'b0;
            sprite_sel  <= 4'b0000;
            attack_busy <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            dir_reg     <= dir_nx;
            frame_q     <= frame_clk;
            atk_pend    <= atk_pend_nx;
            sprite_sel  <= {dir_nx, pose_nx};
            attack_busy <= (state_nx == ATTACK);
        end
    end

endmodule

// File: tb/tb_link_anim_ctrl.sv
// Directed bench for link_anim_ctrl with default parameters (WALK_PERIOD=8, ATTACK_FRAMES=16).
module tb_link_anim_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [1:0] dir_in;
    logic       moving;
    logic       attack_req;
    logic [3:0] sprite_sel;
    logic       attack_busy;

    int total = 0;
    int bad   = 0;

    link_anim_ctrl #(.WALK_PERIOD(8), .ATTACK_FRAMES(16)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .dir_in     (dir_in),
        .moving     (moving),
        .attack_req (attack_req),
        .sprite_sel (sprite_sel),
        .attack_busy(attack_busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame: frame_clk high for one cycle; returns on the negedge after the update edge
    task automatic frame();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; dir_in = 2'd0; moving = 1'b0; attack_req = 1'b0;
        idle_cycles(3);
        chk("rst_sel", {4'h0, sprite_sel}, 8'h00);
        chk("rst_busy", {7'h0, attack_busy}, 8'h00);
        Reset = 1'b0;
        idle_cycles(2);

        // Idle frames pick up facing, no attack
        dir_in = 2'd2;
        for (int i = 1; i <= 3; i++) begin
            frame();
            chk($sformatf("idle_sel_%0d", i), {4'h0, sprite_sel}, 8'h08);
            chk($sformatf("idle_busy_%0d", i), {7'h0, attack_busy}, 8'h00);
        end

        // Walk cycle: 8 ticks per pose
        dir_in = 2'd0; moving = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            frame();
            chk($sformatf("walk_sel_%0d", i), {4'h0, sprite_sel},
                (i >= 9 && i <= 16) ? 8'h01 : 8'h00);
        end

        // Outputs hold between ticks
        dir_in = 2'd3; moving = 1'b0;
        idle_cycles(3);
        chk("hold_sel", {4'h0, sprite_sel}, 8'h00);

        // 1-cycle attack pulse between ticks while walking
        moving = 1'b1; dir_in = 2'd1;
        @(negedge Clk) attack_req = 1'b1;
        @(negedge Clk) attack_req = 1'b0;
        chk("pend_set", {7'h0, dut.atk_pend}, 8'h01);
        chk("pre_atk_sel", {4'h0, sprite_sel}, 8'h00);
        for (int i = 1; i <= 16; i++) begin
            dir_in = 2'(i);
            if (i == 5) begin
                @(negedge Clk) attack_req = 1'b1;
                @(negedge Clk) attack_req = 1'b0;
            end
            frame();
            chk($sformatf("atk_sel_%0d", i), {4'h0, sprite_sel}, 8'h02);
            chk($sformatf("atk_busy_%0d", i), {7'h0, attack_busy}, 8'h01);
            if (i == 1) chk("atk_pend_clr", {7'h0, dut.atk_pend}, 8'h00);
        end
        dir_in = 2'd3; moving = 1'b0;
        frame();
        chk("atk_exit_sel", {4'h0, sprite_sel}, 8'h0C);
        chk("atk_exit_busy", {7'h0, attack_busy}, 8'h00);
        frame();
        chk("post_idle_busy", {7'h0, attack_busy}, 8'h00);
        chk("post_idle_pend", {7'h0, dut.atk_pend}, 8'h00);

        // frame_clk held high for 10 cycles gives one tick
        moving = 1'b1; dir_in = 2'd2;
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) dir_in = 2'd3;
        idle_cycles(9);
        chk("held_sel", {4'h0, sprite_sel}, 8'h08);
        chk("held_cnt", dut.cnt, 8'h00);
        frame_clk = 1'b0;
        idle_cycles(1);

        // Attack request coincident with tick
        dir_in = 2'd1;
        @(negedge Clk) begin frame_clk = 1'b1; attack_req = 1'b1; end
        @(negedge Clk) begin frame_clk = 1'b0; attack_req = 1'b0; end
        chk("coinc_sel", {4'h0, sprite_sel}, 8'h0A);
        chk("coinc_busy", {7'h0, attack_busy}, 8'h01);
        chk("coinc_pend", {7'h0, dut.atk_pend}, 8'h00);

        // Reset mid-attack at cnt=5
        for (int i = 0; i < 5; i++) frame();
        chk("atk_cnt5", dut.cnt, 8'h05);
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
        chk("midrst_sel", {4'h0, sprite_sel}, 8'h00);
        chk("midrst_busy", {7'h0, attack_busy}, 8'h00);
        chk("midrst_pend", {7'h0, dut.atk_pend}, 8'h00);
        dir_in = 2'd0; moving = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            frame();
            chk($sformatf("rewalk_sel_%0d", i), {4'h0, sprite_sel}, (i == 9) ? 8'h01 : 8'h00);
        end

        // Reset and frame_clk rise together: tick lands on the following cycle
        moving = 1'b0; dir_in = 2'd1;
        @(negedge Clk) begin Reset = 1'b1; frame_clk = 1'b1; end
        @(negedge Clk) Reset = 1'b0;
        chk("rst_tick_sel0", {4'h0, sprite_sel}, 8'h00);
        @(negedge Clk) frame_clk = 1'b0;
        chk("rst_tick_sel1", {4'h0, sprite_sel}, 8'h04);
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
